// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer, branch control, instruction memory and decode.
// The sequencer side is the master modport; the environment uses the slave modport.
interface pc_sequencer_if;
    logic [1:0]  pcsel;
    logic        redir_valid;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;

    modport master (
        input  pcsel, redir_valid, branch_target, jump_target, stall, imem_ack,
        output imem_req, imem_addr, pc, pc_valid, flush
    );

    modport slave (
        output pcsel, redir_valid, branch_target, jump_target, stall, imem_ack,
        input  imem_req, imem_addr, pc, pc_valid, flush
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: RST/FETCH/HOLD control with one outstanding fetch and redirect handling.
// Build option PCSEQ_DELAY_SLOT_EN: branch delay slot instead of squash-and-flush.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_sequencer_if.master       bus
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic        pend_r;
    logic        pend_next_s;
    logic [31:0] pend_tgt_r;
    logic [31:0] pend_tgt_next_s;
    logic        flush_r;
    logic        flush_next_s;
    logic        accept_s;
    logic [31:0] acc_tgt_s;
    logic        deliver_s;
    logic        apply_s;
    logic [31:0] apply_tgt_s;
    logic        squash_s;

    // Next-state, redirect capture and PC selection
    always_comb begin
        state_next_s    = state_r;
        pc_next_s       = pc_r;
        pend_next_s     = pend_r;
        pend_tgt_next_s = pend_tgt_r;
        flush_next_s    = 1'b0;
        accept_s        = 1'b0;
        acc_tgt_s       = 32'h0000_0000;
        deliver_s       = 1'b0;
        apply_s         = 1'b0;
        apply_tgt_s     = pend_tgt_r;
        squash_s        = 1'b0;

        if (!rst && (state_r != ST_RST) && bus.redir_valid) begin
            case (bus.pcsel)
                2'b01: begin
                    accept_s  = 1'b1;
                    acc_tgt_s = {bus.branch_target[31:2], 2'b00};
                end
                2'b10: begin
                    accept_s  = 1'b1;
                    acc_tgt_s = {bus.jump_target[31:2], 2'b00};
                end
                default: begin
                    accept_s  = 1'b0;
                    acc_tgt_s = 32'h0000_0000;
                end
            endcase
        end else begin
            accept_s = 1'b0;
        end

        case (state_r)
            ST_RST: begin
                state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    state_next_s = bus.stall ? ST_HOLD : ST_FETCH;
                    deliver_s    = !bus.stall && !rst;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (bus.stall) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_FETCH;
                    deliver_s    = !rst;
                end
            end
            default: begin
                state_next_s = ST_RST;
            end
        endcase

`ifdef PCSEQ_DELAY_SLOT_EN
        // Only a redirect armed before this delivery applies, so the delivery
        // following acceptance is the delay slot and is never squashed.
        apply_s     = deliver_s && pend_r;
        apply_tgt_s = pend_tgt_r;
        if (accept_s) begin
            pend_next_s     = 1'b1;
            pend_tgt_next_s = acc_tgt_s;
        end else if (apply_s) begin
            pend_next_s = 1'b0;
        end else begin
            pend_next_s = pend_r;
        end
`else
        apply_s      = deliver_s && (accept_s || pend_r);
        apply_tgt_s  = accept_s ? acc_tgt_s : pend_tgt_r;
        squash_s     = apply_s;
        flush_next_s = accept_s;
        if (apply_s) begin
            pend_next_s = 1'b0;
        end else if (accept_s) begin
            pend_next_s     = 1'b1;
            pend_tgt_next_s = acc_tgt_s;
        end else begin
            pend_next_s = pend_r;
        end
`endif

        if (apply_s) begin
            pc_next_s = apply_tgt_s;
        end else if (deliver_s) begin
            pc_next_s = pc_r + 32'd4;
        end else begin
            pc_next_s = pc_r;
        end
    end

    // State, PC, pending redirect and flush registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_RST;
            pc_r       <= RESET_PC;
            pend_r     <= 1'b0;
            pend_tgt_r <= 32'h0000_0000;
            flush_r    <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pc_r       <= pc_next_s;
            pend_r     <= pend_next_s;
            pend_tgt_r <= pend_tgt_next_s;
            flush_r    <= flush_next_s;
        end
    end

    // pc_valid marks the instruction at the current pc in its delivery cycle,
    // so it is decoded from the state register and this cycle's ack/stall.
    assign bus.pc_valid  = deliver_s && !squash_s;
    assign bus.imem_req  = (state_r == ST_FETCH);
    assign bus.imem_addr = pc_r;
    assign bus.pc        = pc_r;
    assign bus.flush     = flush_r;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded by reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pcsel  input  2  next-PC select from branch control: 00 no load, 01 branch, 10 jump, 11 treated as 00.
REQ-005 redir_valid  input  1  qualifies pcsel for one cycle.
REQ-006 branch_target  input  32  branch destination.
REQ-007 jump_target  input  32  jump destination.
REQ-008 stall  input  1  downstream cannot accept an instruction this cycle.
REQ-009 imem_req  output  1  instruction fetch request.
REQ-010 imem_addr  output  32  fetch address, always equal to pc.
REQ-011 imem_ack  input  1  fetch data returned this cycle.
REQ-012 pc  output  32  current fetch PC.
REQ-013 pc_valid  output  1  one-cycle pulse: instruction at pc delivered downstream.
REQ-014 flush  output  1  one-cycle pulse: squash younger instruction in decode.

Function
REQ-015 States: RST, FETCH, HOLD; encoding is free.
REQ-016 RST: imem_req=0; the next cycle moves to FETCH.
REQ-017 FETCH: imem_req=1; request held until imem_ack, never withdrawn mid-fetch.
REQ-018 FETCH with imem_ack=1 and stall=0: deliver (pc_valid=1 unless squashed), advance pc, stay in FETCH.
REQ-019 FETCH with imem_ack=1 and stall=1: go to HOLD; imem_req=0 in HOLD.
REQ-020 HOLD with stall=0: deliver, advance pc, go to FETCH; HOLD with stall=1: remain.
REQ-021 Advance: next pc = pending redirect target if armed, else pc+4 (32-bit, wraps FFFF_FFFC to 0000_0000).
REQ-022 Redirect accepted in any non-RST cycle with redir_valid=1 and pcsel of 01 or 10; the target is taken from branch_target or jump_target respectively, with bits [1:0] forced to 00.
REQ-023 Accepted redirect is stored as pending; a later accepted redirect before application overwrites it (latest wins).
REQ-024 flush=1 in the cycle after redirect acceptance, for exactly one cycle.
REQ-025 Redirect accepted in the same cycle as a delivery: the redirect applies to that advance (see Configuration for squash rule).
REQ-026 Pending redirect clears when applied; pc loads target, then normal fetch resumes at target.
REQ-027 redir_valid with pcsel 00/11 has no effect.
REQ-028 Only one fetch outstanding at any time; latency from imem_ack (stall=0) to pc update is 1 cycle.

Reset
REQ-029 rst=1 at a clock edge: pc=RESET_PC, state=RST, pending redirect cleared, imem_req=0, pc_valid=0, flush=0.
REQ-030 Reset mid-fetch abandons the outstanding fetch; any imem_ack arriving while in RST is ignored.

Configuration
REQ-031 Macro PCSEQ_DELAY_SLOT_EN selects branch delay-slot behaviour.
REQ-032 Defined: after acceptance, exactly one further sequential instruction is delivered with pc_valid=1, then the target is applied; flush stays 0.
REQ-033 Undefined: the instruction delivered in the acceptance cycle or next outstanding is squashed (pc_valid=0), the target is applied at that advance, and flush pulses per REQ-024.

Verification
REQ-034 Reset, RESET_PC=0, imem_ack tied 1, stall=0 -> pc sequence 0,4,8,C with pc_valid=1 every cycle from the second cycle after reset.
REQ-035 At pc=8, redir_valid=1, pcsel=01, branch_target=0x100 -> no-DS: pc=0x100 next, flush=1 one cycle, pc 8 squashed; DS: 0xC delivered, then 0x100.
REQ-036 pcsel=10, jump_target=0x203 -> pc loads 0x200.
REQ-037 imem_ack delayed 3 cycles, stall=1 for 2 cycles after ack -> imem_req held through wait, HOLD for 2 cycles, a single pc_valid pulse, pc advances by 4 once.
REQ-038 pc=FFFF_FFFC, no redirect -> next pc 0000_0000.
REQ-039 rst asserted while waiting on imem_ack, ack returns in the reset cycle -> pc=RESET_PC, pc_valid=0, pending cleared.
